// File: rtl/hf_bus_interconnect_pkg.sv
// Shared types, region constants and byte-swap helpers for the HF-RISCV bus fabric.
package hf_bus_pkg;

  localparam logic [3:0] REGION_BOOT   = 4'h0;
  localparam logic [3:0] REGION_RAM    = 4'h4;
  localparam logic [3:0] REGION_PERIPH = 4'he;

  // Slave index; NONE sits above the largest legal index (7) so it never aliases a port.
  typedef logic [3:0] slv_idx_t;
  localparam slv_idx_t SEL_NONE = 4'hf;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [3:0] bswap_we4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

endpackage

// File: rtl/hf_bus_interconnect_if.sv
// Core-side and slave-side bus signals of the fabric; "slave" is the fabric's own view.
interface hf_bus_interconnect_if #(
  parameter int N_SLV = 4
);
  logic [31:0]             m_addr_i;
  logic [31:0]             m_data_i;
  logic [3:0]              m_we_i;
  logic                    m_stall_o;
  logic [31:0]             m_data_o;
  logic                    err_o;
  logic [N_SLV-1:0]        s_sel_o;
  logic [3:0]              s_we_o;
  logic [31:0]             s_data_o;
  logic [N_SLV-1:0][31:0]  s_data_i;

  modport master (
    output m_addr_i, m_data_i, m_we_i, s_data_i,
    input  m_stall_o, m_data_o, err_o, s_sel_o, s_we_o, s_data_o
  );

  modport slave (
    input  m_addr_i, m_data_i, m_we_i, s_data_i,
    output m_stall_o, m_data_o, err_o, s_sel_o, s_we_o, s_data_o
  );
endinterface

// File: rtl/hf_bus_interconnect_region_decode.sv
// Priority address decoder: addr[31:28] -> one-hot select, index and miss flag.
module hf_bus_region_decode
  import hf_bus_pkg::*;
#(
  parameter int               N_SLV      = 4,
  parameter logic [N_SLV*4-1:0] REGION_MAP = '0
) (
  input  logic [3:0]       nibble_i,
  output logic [N_SLV-1:0] oh_o,
  output slv_idx_t         idx_o,
  output logic             miss_o
);

  // Scan from the top down so the lowest matching slave is the last writer.
  always_comb begin
    oh_o  = '0;
    idx_o = SEL_NONE;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (nibble_i == REGION_MAP[k*4 +: 4]) begin
        oh_o    = '0;
        oh_o[k] = 1'b1;
        idx_o   = slv_idx_t'(k);
      end
    end
    miss_o = (idx_o == SEL_NONE);
  end

endmodule

// File: rtl/hf_bus_interconnect.sv
// Single-master/N-slave fabric: decode, per-slave wait states, byte-lane swap and read steering.
module hf_bus_interconnect
  import hf_bus_pkg::*;
#(
  parameter int                 N_SLV      = 4,
  parameter logic [N_SLV*4-1:0] REGION_MAP = {4'hf, REGION_PERIPH, REGION_RAM, REGION_BOOT},
  parameter logic [N_SLV*4-1:0] WAIT_MAP   = {4'd2, 4'd0, 4'd0, 4'd0},
  parameter logic [N_SLV-1:0]   SWAP_MAP   = 4'b0100
) (
  input logic                  clk_i,
  input logic                  rst_i,
  hf_bus_interconnect_if.slave bus
);

  logic [N_SLV-1:0] hit_oh;
  slv_idx_t         hit_idx;
  logic             miss;

  hf_bus_region_decode #(
    .N_SLV      (N_SLV),
    .REGION_MAP (REGION_MAP)
  ) u_dec (
    .nibble_i (bus.m_addr_i[31:28]),
    .oh_o     (hit_oh),
    .idx_o    (hit_idx),
    .miss_o   (miss)
  );

  logic unused_addr;
  assign unused_addr = ^bus.m_addr_i[27:0];

  function automatic logic [3:0] wait_of(input slv_idx_t i);
    wait_of = 4'd0;
    for (int k = 0; k < N_SLV; k++)
      if (i == slv_idx_t'(k)) wait_of = WAIT_MAP[k*4 +: 4];
  endfunction

  function automatic logic swap_of(input slv_idx_t i);
    swap_of = 1'b0;
    for (int k = 0; k < N_SLV; k++)
      if (i == slv_idx_t'(k)) swap_of = SWAP_MAP[k];
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  slv_idx_t   slv_q, slv_d;
  slv_idx_t   rd_sel_q, rd_sel_d;
  logic       err_q, err_d;

  logic [N_SLV-1:0] sel;
  slv_idx_t         cur_idx;
  logic             stall, we_en, swp;
  logic [31:0]      rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slv_d    = slv_q;
    rd_sel_d = rd_sel_q;
    err_d    = 1'b0;
    sel      = '0;
    cur_idx  = SEL_NONE;
    stall    = 1'b0;
    we_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          err_d    = 1'b1;
          rd_sel_d = SEL_NONE;
        end else begin
          sel     = hit_oh;
          cur_idx = hit_idx;
          if (wait_of(hit_idx) == 4'd0) begin
            we_en    = 1'b1;
            rd_sel_d = hit_idx;
          end else begin
            stall   = 1'b1;
            slv_d   = hit_idx;
            cnt_d   = wait_of(hit_idx) - 4'd1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Address is not re-decoded here; the latched slave owns the access.
        cur_idx = slv_q;
        for (int k = 0; k < N_SLV; k++) sel[k] = (slv_q == slv_idx_t'(k));
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          we_en    = 1'b1;
          rd_sel_d = slv_q;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      slv_q    <= '0;
      rd_sel_q <= SEL_NONE;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slv_q    <= slv_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_SLV; k++)
      if (rd_sel_q == slv_idx_t'(k))
        rdata = SWAP_MAP[k] ? bswap32(bus.s_data_i[k]) : bus.s_data_i[k];
  end

  // Combinational strobes are gated by reset so an abort drops them without a clock.
  assign swp           = swap_of(cur_idx);
  assign bus.m_stall_o = rst_i & stall;
  assign bus.s_sel_o   = rst_i ? sel : '0;
  assign bus.s_we_o    = (rst_i && we_en) ? (swp ? bswap_we4(bus.m_we_i) : bus.m_we_i) : 4'h0;
  assign bus.s_data_o  = swp ? bswap32(bus.m_data_i) : bus.m_data_i;
  assign bus.err_o     = err_q;
  assign bus.m_data_o  = rdata;

endmodule

// File: tb/tb_hf_bus_interconnect.sv
// Directed + random checks of hf_bus_interconnect against a transaction-level model.
module tb_hf_bus_interconnect;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  hf_bus_interconnect_if #(.N_SLV(4)) bus_a ();
  hf_bus_interconnect_if #(.N_SLV(4)) bus_b ();

  hf_bus_interconnect #(
    .N_SLV(4), .REGION_MAP(16'hFE40), .WAIT_MAP(16'h2000), .SWAP_MAP(4'b0100)
  ) dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_a));

  hf_bus_interconnect #(
    .N_SLV(4), .REGION_MAP(16'hF440), .WAIT_MAP(16'h0000), .SWAP_MAP(4'b0000)
  ) dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  // Slave-ordered model tables for dut_a (slave 0 first).
  logic [3:0]  reg_a  [4] = '{4'h0, 4'h4, 4'hE, 4'hF};
  int          wait_a [4] = '{0, 0, 0, 2};
  bit          swap_a [4] = '{0, 0, 1, 0};
  logic [31:0] sd_a   [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] sd_b   [4] = '{32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333};

  assign bus_a.s_data_i = {sd_a[3], sd_a[2], sd_a[1], sd_a[0]};
  assign bus_b.s_data_i = {sd_b[3], sd_b[2], sd_b[1], sd_b[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = x[8*i +: 8];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[3-i] = x[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // One full core access on dut_a: stall cycles, completion cycle, then read-data cycle.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    int          k;
    logic [3:0]  esel, ewe;
    logic [31:0] ewd, erd;
    k = -1;
    for (int j = 0; j < 4; j++)
      if (k < 0 && addr[31:28] == reg_a[j]) k = j;
    bus_a.m_addr_i = addr;
    bus_a.m_we_i   = we;
    bus_a.m_data_i = wd;
    #1;
    if (k < 0) begin
      chk("unmap_sel", bus_a.s_sel_o, 4'b0000);
      chk("unmap_stall", bus_a.m_stall_o, 1'b0);
      chk("unmap_we", bus_a.s_we_o, 4'b0000);
      tick();
      chk("unmap_err", bus_a.err_o, 1'b1);
      chk("unmap_rdata", bus_a.m_data_o, 32'h0);
    end else begin
      esel = 4'(1 << k);
      ewe  = swap_a[k] ? rev4(we) : we;
      ewd  = swap_a[k] ? rev32(wd) : wd;
      erd  = swap_a[k] ? rev32(sd_a[k]) : sd_a[k];
      for (int c = 0; c < wait_a[k]; c++) begin
        chk("wait_stall", bus_a.m_stall_o, 1'b1);
        chk("wait_sel", bus_a.s_sel_o, esel);
        chk("wait_we", bus_a.s_we_o, 4'b0000);
        tick();
      end
      chk("done_stall", bus_a.m_stall_o, 1'b0);
      chk("done_sel", bus_a.s_sel_o, esel);
      chk("done_we", bus_a.s_we_o, ewe);
      chk("done_wdata", bus_a.s_data_o, ewd);
      tick();
      chk("rdata", bus_a.m_data_o, erd);
      chk("no_err", bus_a.err_o, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    bus_a.m_addr_i = 32'h0000_0010;
    bus_a.m_we_i   = 4'hF;
    bus_a.m_data_i = 32'h0;
    bus_b.m_addr_i = 32'h0000_0000;
    bus_b.m_we_i   = 4'h0;
    bus_b.m_data_i = 32'h0;

    // Reset values, with a mapped address already presented.
    repeat (2) tick();
    chk("rst_stall", bus_a.m_stall_o, 1'b0);
    chk("rst_sel", bus_a.s_sel_o, 4'b0000);
    chk("rst_we", bus_a.s_we_o, 4'b0000);
    chk("rst_rdata", bus_a.m_data_o, 32'h0);
    chk("rst_err", bus_a.err_o, 1'b0);
    bus_a.m_we_i = 4'h0;
    rst_i = 1'b1;

    // Directed scenarios.
    sd_a[0] = 32'h1122_3344;
    xfer(32'h0000_0010, 4'h0, 32'h0);
    sd_a[3] = 32'hCAFE_F00D;
    xfer(32'hF000_0000, 4'h0, 32'h0);
    sd_a[2] = 32'h0102_0304;
    xfer(32'hE000_0000, 4'b0001, 32'hAABB_CCDD);
    xfer(32'h8000_0000, 4'hF, 32'h1234_5678);
    sd_a[1] = 32'h5555_AAAA;
    xfer(32'h4000_0100, 4'b0011, 32'h0BAD_BEEF);
    xfer(32'hF000_0004, 4'b1111, 32'h7777_8888);

    // Random back-to-back traffic.
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 4; j++) sd_a[j] = $urandom;
      a = $urandom;
      a[31:28] = 4'($urandom_range(15, 0));
      xfer(a, 4'($urandom_range(15, 0)), $urandom);
    end

    // Reset during the second stall cycle of a write to slave 3.
    bus_a.m_addr_i = 32'hF000_0000;
    bus_a.m_we_i   = 4'hF;
    bus_a.m_data_i = 32'hDEAD_BEEF;
    #1;
    chk("abort_stall1", bus_a.m_stall_o, 1'b1);
    tick();
    chk("abort_stall2", bus_a.m_stall_o, 1'b1);
    chk("abort_we_pre", bus_a.s_we_o, 4'b0000);
    rst_i = 1'b0;
    #1;
    chk("abort_stall", bus_a.m_stall_o, 1'b0);
    chk("abort_sel", bus_a.s_sel_o, 4'b0000);
    chk("abort_we", bus_a.s_we_o, 4'b0000);
    chk("abort_rdata", bus_a.m_data_o, 32'h0);
    chk("abort_err", bus_a.err_o, 1'b0);
    tick();
    chk("abort_we_hold", bus_a.s_we_o, 4'b0000);
    chk("abort_sel_hold", bus_a.s_sel_o, 4'b0000);
    bus_a.m_addr_i = 32'h0000_0010;
    bus_a.m_we_i   = 4'h0;
    sd_a[0] = 32'h600D_CAFE;
    rst_i = 1'b1;
    #1;
    chk("post_rst_sel", bus_a.s_sel_o, 4'b0001);
    chk("post_rst_stall", bus_a.m_stall_o, 1'b0);
    tick();
    chk("post_rst_rdata", bus_a.m_data_o, 32'h600D_CAFE);

    // Overlapping regions: the lower-numbered slave takes the access.
    bus_b.m_addr_i = 32'h4000_0000;
    #1;
    chk("ovl_sel", bus_b.s_sel_o, 4'b0010);
    tick();
    chk("ovl_rdata", bus_b.m_data_o, 32'hB1B1_1111);
    bus_b.m_addr_i = 32'hF000_0000;
    #1;
    chk("ovl_sel3", bus_b.s_sel_o, 4'b1000);
    chk("ovl_stall3", bus_b.m_stall_o, 1'b0);
    tick();
    chk("ovl_rdata3", bus_b.m_data_o, 32'hB3B3_3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
